fp_adder_sequential: RTL and testbench
======================================

// Module: fp_adder_sequential
// PURPOSE
//  Pipelined IEEE-754 single-precision adder: result = a + b, with a saturation overflow flag.
//  Accepts a new operand pair every clock; results appear after a fixed latency.
//  Standalone arithmetic datapath block with no handshake; the consumer samples after the latency.
// PARAMETERS
//  EXP_W   8    exponent width (fixed; other values unsupported)
//  MAN_W   23   stored mantissa width (fixed)
//  BIAS    127  exponent bias
// PORTS
//  clk       in   1   single clock, rising edge
//  rst       in   1   asynchronous, active-low reset
//  a         in   32  operand A (sign[31], exp[30:23], man[22:0])
//  b         in   32  operand B, same format
//  result    out  32  registered sum
//  overflow  out  1   registered; 1 when result saturated
// BEHAVIOUR
//  - Reset: rst=0 asynchronously clears all pipeline registers; result=32'h0, overflow=0.
//  - Pipeline, 3 cycles (FP_ADD_IN_REG_EN defined):
//    S1 registers a,b. S2 unpacks, aligns and adds/subtracts. S3 normalizes, packs and registers outputs.
//    Operands sampled at edge N produce result/overflow valid after edge N+2.
//  - Unpack: exp!=0 -> hidden 1 prepended (24-bit significand).
//    exp==0 -> operand treated as zero (denormals flushed).
//  - Align: the operand with the smaller exponent is right-shifted by the exponent difference.
//    Shifted-out bits are discarded; there are no guard/round/sticky bits.
//    A difference >=24 gives 0.
//  - Same signs: add magnitudes and keep the sign.
//  - Different signs: subtract smaller from larger magnitude; the sign is taken from the larger.
//  - Normalize: on carry out, shift right 1 (LSB dropped) and exp+1.
//    Otherwise left-shift by the leading-zero count (zeros in), with exp minus that count.
//  - Rounding: truncation only (round toward zero).
//  - Zero: a zero magnitude sum (incl. exact cancellation, 0+0) -> 32'h00000000, overflow=0.
//  - Underflow: a normalized exp <=0 -> +0, overflow=0.
//  - Overflow: a normalized exp >=255, or any input exp==255, gives saturation.
//    result = {sign,31'h7FFFFFFF}, overflow=1.
//    Sign is that of the larger-magnitude operand (or of A on a tie).
//  - No stall or hold: the outputs update every cycle and the pipeline is never frozen except by reset.
//  - Reset mid-operation discards all in-flight results; the first valid output follows full latency after release.
// CONFIGURATION
//  FP_ADD_IN_REG_EN
//    defined: S1 input register present, latency 3 cycles.
//    undefined: a,b feed S2 logic directly, latency 2 cycles, with identical arithmetic.
// STRUCTURE
//  - Package fp_adder_pkg holds:
//    - EXP_W, MAN_W, BIAS and EXP_MAX=255 constants;
//    - the SAT_MAG=31'h7FFFFFFF constant;
//    - a packed struct fp32_t {sign, exp, man};
//    - the S2->S3 pipeline struct (sign, exp[9:0] signed, sum[24:0], force_ovf).
//  - Sub-module fp_lzc24: a 24-bit leading-zero counter (5-bit count, count=24 for zero), used in S3.
// TESTING
//  - 7F7FFFFF + 7F7FFFFF -> result 7FFFFFFF, overflow 1.
//  - FF7FFFFF + FF7FFFFF -> result FFFFFFFF, overflow 1.
//  - 40A851EC + C18C6666 -> C144A3D6, overflow 0 (mixed-sign subtract, left normalize).
//  - Same-sign adds with truncation, all with overflow 0:
//    - 41139168 + 45AFE8CD -> 45B03295;
//    - 47AEDB0F + 48EAFC7C -> 490B599F (carry out);
//    - C5BB09D7 + C5AA98CD -> C632D152.
//  - 0 + 0 -> 00000000, overflow 0; also 3F800000 + BF800000 -> 00000000 (exact cancel).
//  - Assert rst low mid-stream -> outputs 0 immediately.
//    Back-to-back operands every cycle -> each result appears exactly at latency, in order.

Source files
------------

// File: rtl/fp_adder_pkg.sv
// Shared types and constants for the single-precision pipelined adder.
package fp_adder_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;
  localparam logic [30:0]      SAT_MAG = 31'h7FFFFFFF;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  // Aligned sum handed from the add stage to the normalize stage.
  typedef struct packed {
    logic               sign;
    logic signed [9:0]  exp;
    logic [24:0]        sum;
    logic               force_ovf;
  } s2_t;

endpackage

// File: rtl/fp_lzc24.sv
// 24-bit leading-zero counter; returns 24 for an all-zero input.
module fp_lzc24 (
  input  logic [23:0] din,
  output logic [4:0]  cnt
);

  // Ascending scan: the most significant set bit is the last one to write cnt.
  always_comb begin
    cnt = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (din[i]) cnt = 5'(23 - i);
    end
  end

endmodule

// File: rtl/fp_adder_sequential.sv
// Pipelined IEEE-754 single-precision adder with truncation and saturation.
// FP_ADD_IN_REG_EN adds an input register stage (latency 3 instead of 2).
module fp_adder_sequential
  import fp_adder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        overflow
);

  fp32_t fa, fb;

`ifdef FP_ADD_IN_REG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fa <= '0;
      fb <= '0;
    end else begin
      fa <= a;
      fb <= b;
    end
  end
`else
  assign fa = a;
  assign fb = b;
`endif

  // Add stage: flush denormals, pick the larger magnitude, align the smaller.
  logic [23:0] sig_a, sig_b, sig_l, sig_s, sig_sh;
  logic [30:0] key_a, key_b;
  logic [7:0]  exp_l, exp_s, exp_diff;
  logic        a_big;
  s2_t         s2_d, s2_q;

  always_comb begin
    sig_a    = (fa.exp != 8'd0) ? {1'b1, fa.man} : 24'd0;
    sig_b    = (fb.exp != 8'd0) ? {1'b1, fb.man} : 24'd0;
    key_a    = (fa.exp != 8'd0) ? {fa.exp, fa.man} : 31'd0;
    key_b    = (fb.exp != 8'd0) ? {fb.exp, fb.man} : 31'd0;
    a_big    = (key_a >= key_b);
    sig_l    = a_big ? sig_a : sig_b;
    sig_s    = a_big ? sig_b : sig_a;
    exp_l    = a_big ? fa.exp : fb.exp;
    exp_s    = a_big ? fb.exp : fa.exp;
    exp_diff = exp_l - exp_s;
    sig_sh   = (exp_diff >= 8'd24) ? 24'd0 : (sig_s >> exp_diff);

    s2_d.sign      = a_big ? fa.sign : fb.sign;
    s2_d.exp       = {2'b00, exp_l};
    s2_d.sum       = (fa.sign == fb.sign) ? ({1'b0, sig_l} + {1'b0, sig_sh})
                                          : ({1'b0, sig_l} - {1'b0, sig_sh});
    s2_d.force_ovf = (fa.exp == EXP_MAX) || (fb.exp == EXP_MAX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) s2_q <= '0;
    else      s2_q <= s2_d;
  end

  // Normalize stage.
  logic [4:0]        lz;
  logic signed [9:0] exp_n;
  logic [22:0]       man_n;
  logic [31:0]       res_d;
  logic              ovf_d;

  fp_lzc24 u_lzc (
    .din (s2_q.sum[23:0]),
    .cnt (lz)
  );

  always_comb begin
    if (s2_q.sum[24]) begin
      man_n = s2_q.sum[23:1];
      exp_n = s2_q.exp + 10'sd1;
    end else begin
      // Only the 23 stored bits survive, so shifting the low 23 bits suffices.
      man_n = s2_q.sum[22:0] << lz;
      exp_n = s2_q.exp - $signed({5'b00000, lz});
    end

    res_d = 32'd0;
    ovf_d = 1'b0;
    if (s2_q.force_ovf || exp_n >= 10'sd255) begin
      res_d = {s2_q.sign, SAT_MAG};
      ovf_d = 1'b1;
    end else if (s2_q.sum == 25'd0 || exp_n <= 10'sd0) begin
      res_d = 32'd0;
    end else begin
      res_d = {s2_q.sign, exp_n[7:0], man_n};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result   <= 32'd0;
      overflow <= 1'b0;
    end else begin
      result   <= res_d;
      overflow <= ovf_d;
    end
  end

endmodule

// File: tb/tb_fp_adder_sequential.sv
// Directed-vector bench for fp_adder_sequential with hand-computed sums.
module tb_fp_adder_sequential;

`ifdef FP_ADD_IN_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] a   = 32'd0;
  logic [31:0] b   = 32'd0;
  logic [31:0] result;
  logic        overflow;

  int tests_run = 0;
  int fail_cnt  = 0;

  logic [32:0] exp_q[$];

  fp_adder_sequential dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .result   (result),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    tests_run++;
    assert (got === exp_v) else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp_v);
    end
  endtask

  // Drive one pair, wait the pipeline latency, check both outputs.
  task automatic do_op(input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] er, input logic eo, input string tag);
    @(negedge clk);
    a = av;
    b = bv;
    repeat (LAT) @(posedge clk);
    #1;
    check({tag, ".result"}, result, er);
    check({tag, ".overflow"}, {31'd0, overflow}, {31'd0, eo});
  endtask

  logic [31:0] va [8] = '{32'h41139168, 32'h47AEDB0F, 32'hC5BB09D7, 32'h40A851EC,
                          32'h7F7FFFFF, 32'h3F800000, 32'hFF7FFFFF, 32'h00000000};
  logic [31:0] vb [8] = '{32'h45AFE8CD, 32'h48EAFC7C, 32'hC5AA98CD, 32'hC18C6666,
                          32'h7F7FFFFF, 32'h3F800000, 32'hFF7FFFFF, 32'h00000000};
  logic [31:0] vr [8] = '{32'h45B03295, 32'h490B599F, 32'hC632D152, 32'hC144A3D6,
                          32'h7FFFFFFF, 32'h40000000, 32'hFFFFFFFF, 32'h00000000};
  logic        vo [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    logic [32:0] e;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset.result", result, 32'h0);
    check("reset.overflow", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed vectors.
    do_op(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7FFFFFFF, 1'b1, "max_plus_max");
    do_op(32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFFFFFFFF, 1'b1, "negmax_plus_negmax");
    do_op(32'h40A851EC, 32'hC18C6666, 32'hC144A3D6, 1'b0, "mixed_sub");
    do_op(32'h41139168, 32'h45AFE8CD, 32'h45B03295, 1'b0, "same_sign_trunc");
    do_op(32'h47AEDB0F, 32'h48EAFC7C, 32'h490B599F, 1'b0, "carry_out");
    do_op(32'hC5BB09D7, 32'hC5AA98CD, 32'hC632D152, 1'b0, "neg_add");
    do_op(32'h00000000, 32'h00000000, 32'h00000000, 1'b0, "zero_plus_zero");
    do_op(32'h3F800000, 32'hBF800000, 32'h00000000, 1'b0, "exact_cancel");
    do_op(32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, "one_plus_one");
    do_op(32'h00000005, 32'h3F800000, 32'h3F800000, 1'b0, "denorm_flush");
    do_op(32'h3F800000, 32'h33000000, 32'h3F800000, 1'b0, "big_exp_diff");
    do_op(32'h00800001, 32'h80800000, 32'h00000000, 1'b0, "underflow");
    do_op(32'h7F800000, 32'h3F800000, 32'h7FFFFFFF, 1'b1, "inf_input");
    do_op(32'h3F800000, 32'hFF800000, 32'hFFFFFFFF, 1'b1, "neg_inf_larger");

    // Back-to-back stream: each result must land exactly LAT edges after sampling.
    for (int c = 0; c < 8 + LAT; c++) begin
      @(negedge clk);
      if (c < 8) begin
        a = va[c];
        b = vb[c];
        exp_q.push_back({vo[c], vr[c]});
      end
      @(posedge clk);
      #1;
      if (c >= LAT - 1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stream.result", result, e[31:0]);
        check("stream.overflow", {31'd0, overflow}, {31'd0, e[32]});
      end
    end

    // Asynchronous reset mid-stream.
    do_op(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7FFFFFFF, 1'b1, "pre_reset");
    #2;
    rst = 1'b0;
    #1;
    check("async_reset.result", result, 32'h0);
    check("async_reset.overflow", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    a = 32'h3F800000;
    b = 32'h3F800000;
    @(negedge clk);
    rst = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    #1;
    check("post_reset_early", result, 32'h0);
    @(posedge clk);
    #1;
    check("post_reset_first", result, 32'h40000000);
    check("post_reset_ovf", {31'd0, overflow}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
